pulse_dispatch_ctrl: RTL and testbench

PULSE_DISPATCH_CTRL -- requirements
Module: pulse_dispatch_ctrl

---
 rtl/caotai_pkg.sv | 17 +
 rtl/pulse_inflight_tracker.sv | 52 +++++
 rtl/pulse_dispatch_ctrl.sv | 133 +++++++++++++
 tb/tb_pulse_dispatch_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/caotai_pkg.sv
// Shared definitions for the pulse dispatch controller.
//   state_t      : FSM encoding (binary, 2 bits)
//   DEF_RD_LAT   : default read-to-decrement latency of the occupancy counter
//   DEF_WID      : default width of pulse counts and the period setting
package caotai_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_RD_LAT = 4;
  localparam int DEF_WID    = 16;

endpackage

// File: rtl/pulse_inflight_tracker.sv
// Tracks rd_pulse strobes whose decrement has not yet reached pulse_num and
// derives the count of pulses still available for dispatch.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   rd_pulse    : registered consume strobe of the current cycle
//   pulse_num   : pending count reported by the occupancy counter
//   inflight    : strobes issued whose decrement is not yet visible
//   avail       : pulse_num - inflight, clamped at 0
//   underrun    : pulse_num < inflight this cycle
module pulse_inflight_tracker #(
  parameter int WID    = 16,
  parameter int RD_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rd_pulse,
  input  logic [WID-1:0] pulse_num,
  output logic [WID-1:0] inflight,
  output logic [WID-1:0] avail,
  output logic           underrun
);

  localparam int CW = $clog2(RD_LAT + 1);

  logic [RD_LAT-1:0] r_sr;   // r_sr[k] = rd_pulse from k+1 cycles ago
  logic [CW-1:0]     r_cnt;  // population count of r_sr
  logic [RD_LAT:0]   w_sr_ext;
  logic              w_oldest;
  logic [CW-1:0]     w_inflight;

  assign w_sr_ext = {r_sr, rd_pulse};
  assign w_oldest = r_sr[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr  <= w_sr_ext[RD_LAT-1:0];
      r_cnt <= r_cnt + CW'(rd_pulse) - CW'(w_oldest);
    end
  end

  // The strobe from RD_LAT cycles ago is already reflected in pulse_num, so it
  // is dropped; the strobe of the current cycle is not yet, so it is added.
  // This lets a back-to-back FIRE decision see the pulse being consumed now.
  assign w_inflight = r_cnt - CW'(w_oldest) + CW'(rd_pulse);
  assign inflight   = WID'(w_inflight);
  assign underrun   = (pulse_num < inflight);
  assign avail      = (pulse_num > inflight) ? (pulse_num - inflight) : '0;

endmodule

// File: rtl/pulse_dispatch_ctrl.sv
// Dispatches pending pulses to an actuator with a programmable minimum
// spacing, compensating for the read latency of the occupancy counter.
// Ports:
//   dst_clk, dst_rst : clock, synchronous active-high reset
//   cfg_en           : dispatch enable (level)
//   cfg_period       : minimum rd_pulse spacing in cycles (0 acts as 1)
//   cfg_clr          : one-cycle clear of dispatch_cnt and err_underrun
//   pulse_num        : pending pulse count from the occupancy counter
//   rd_pulse         : one-cycle consume strobe to the occupancy counter
//   step_out         : one-cycle actuator strobe, identical to rd_pulse
//   busy             : controller is not idle
//   dispatch_cnt     : pulses dispatched since reset/clear (wraps)
//   err_underrun     : sticky, pulse_num dropped below the in-flight count
//   dbg_state        : current FSM state
// Handshake: rd_pulse/step_out are single-cycle strobes with no back-pressure;
// every strobe consumes exactly one pulse, seen in pulse_num RD_LAT cycles later.
module pulse_dispatch_ctrl
  import caotai_pkg::*;
#(
  parameter int WID_16 = DEF_WID,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              dst_clk,
  input  logic              dst_rst,
  input  logic              cfg_en,
  input  logic [WID_16-1:0] cfg_period,
  input  logic              cfg_clr,
  input  logic [WID_16-1:0] pulse_num,
  output logic              rd_pulse,
  output logic              step_out,
  output logic              busy,
  output logic [31:0]       dispatch_cnt,
  output logic              err_underrun,
  output logic [1:0]        dbg_state
);

  state_t            r_state;
  state_t            w_next;
  logic [WID_16-1:0] r_gap;
  logic [WID_16-1:0] w_gap_next;
  logic [WID_16-1:0] w_gap_load;
  logic              r_rd;
  logic [31:0]       r_dcnt;
  logic              r_err;
  logic [WID_16-1:0] w_inflight;
  logic [WID_16-1:0] w_avail;
  logic              w_underrun;
  logic              w_go;
  logic              w_fire;

  pulse_inflight_tracker #(
    .WID    (WID_16),
    .RD_LAT (RD_LAT)
  ) u_tracker (
    .clk       (dst_clk),
    .rst       (dst_rst),
    .rd_pulse  (r_rd),
    .pulse_num (pulse_num),
    .inflight  (w_inflight),
    .avail     (w_avail),
    .underrun  (w_underrun)
  );

  // FIRE itself is one of the max(cfg_period,1) cycles of spacing.
  assign w_gap_load = (cfg_period == '0) ? '0 : (cfg_period - WID_16'(1));
  assign w_go       = cfg_en && (w_avail != '0);
  assign w_fire     = (r_state == ST_FIRE);

  always_comb begin
    w_next     = r_state;
    w_gap_next = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (w_go) w_next = ST_FIRE;
      end
      ST_FIRE: begin
        w_gap_next = w_gap_load;
        if (!cfg_en) begin
          w_next     = ST_DRAIN;
          w_gap_next = '0;
        end else if (w_gap_load != '0) begin
          w_next = ST_GAP;
        end else begin
          w_next = w_go ? ST_FIRE : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!cfg_en) begin
          w_next     = ST_DRAIN;
          w_gap_next = '0;
        end else if (r_gap <= WID_16'(1)) begin
          // Last gap cycle: decide now so the next FIRE lands exactly on the period.
          w_gap_next = '0;
          w_next     = w_go ? ST_FIRE : ST_IDLE;
        end else begin
          w_gap_next = r_gap - WID_16'(1);
        end
      end
      ST_DRAIN: begin
        if (w_inflight == '0) w_next = ST_IDLE;
      end
      default: begin
        w_next     = ST_IDLE;
        w_gap_next = '0;
      end
    endcase
  end

  always_ff @(posedge dst_clk) begin
    if (dst_rst) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      r_rd    <= 1'b0;
      r_dcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gap   <= w_gap_next;
      r_rd    <= (w_next == ST_FIRE);
      // A clear coinciding with a FIRE still counts that FIRE.
      r_dcnt  <= cfg_clr ? {31'd0, w_fire} : (r_dcnt + {31'd0, w_fire});
      r_err   <= cfg_clr ? 1'b0 : (r_err | w_underrun);
    end
  end

  assign rd_pulse     = r_rd;
  assign step_out     = r_rd;
  assign busy         = (r_state != ST_IDLE);
  assign dispatch_cnt = r_dcnt;
  assign err_underrun = r_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_pulse_dispatch_ctrl.sv
`timescale 1ns/1ps
module tb_pulse_dispatch_ctrl;

  localparam int RD_LAT = 4;

  // ---------------- clock / reset ----------------
  logic        dst_clk = 1'b0;
  logic        dst_rst;
  logic        cfg_en;
  logic [15:0] cfg_period;
  logic        cfg_clr;
  logic [15:0] pulse_num;
  logic        rd_pulse;
  logic        step_out;
  logic        busy;
  logic [31:0] dispatch_cnt;
  logic        err_underrun;
  logic [1:0]  dbg_state;

  always #5 dst_clk = ~dst_clk;

  pulse_dispatch_ctrl #(.WID_16(16), .RD_LAT(RD_LAT)) dut (
    .dst_clk      (dst_clk),
    .dst_rst      (dst_rst),
    .cfg_en       (cfg_en),
    .cfg_period   (cfg_period),
    .cfg_clr      (cfg_clr),
    .pulse_num    (pulse_num),
    .rd_pulse     (rd_pulse),
    .step_out     (step_out),
    .busy         (busy),
    .dispatch_cnt (dispatch_cnt),
    .err_underrun (err_underrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // expected entry: {rd_pulse, busy, err_underrun, dispatch_cnt}
  logic [34:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_prints = 0;

  // environment: occupancy counter
  int occ = 0;
  bit rdq[$];

  // reference model: dispatch history in absolute cycle numbers
  int          cyc = 0;
  int          mf[$];         // cycles in which a strobe is expected
  int          gap_end = 0;   // earliest cycle the next strobe may occur
  bit          draining = 0;
  bit          m_fire = 0;
  logic [31:0] m_dcnt = '0;
  bit          m_err = 0;

  // directed-scenario bookkeeping
  int strobes = 0;
  int fq[$];
  bit rst_on_fire = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Called 2 ns after a rising edge; drives the inputs of cycle `cyc` and
  // pushes the model's prediction for the outputs of cycle `cyc+1`.
  task automatic step(input bit en, input int per, input bit clr,
                      input int add, input bit frc0, input bit rst_i);
    bit rd_now, rst, fire_n, dn, busy_n;
    int inflight, pn, avail, p1;
    rd_now = rd_pulse;
    if (rd_now) begin
      strobes++;
      fq.push_back(cyc);
    end
    rst = rst_i | (rst_on_fire & rd_now);
    // occupancy counter: a strobe shows up as a decrement RD_LAT cycles later
    rdq.push_back(rd_now);
    if (rdq.size() > RD_LAT) begin
      if (rdq.pop_front() && occ > 0) occ--;
    end
    occ += add;
    if (occ > 65535) occ = 65535;
    pn = frc0 ? 0 : occ;
    dst_rst    = rst;
    cfg_en     = en;
    cfg_period = per[15:0];
    cfg_clr    = clr;
    pulse_num  = pn[15:0];

    // strobes issued within the last RD_LAT cycles (current one included)
    while (mf.size() > 0 && mf[0] <= cyc - RD_LAT) void'(mf.pop_front());
    inflight = 0;
    foreach (mf[i]) if (mf[i] <= cyc) inflight++;

    if (rst) begin
      fire_n   = 0;
      busy_n   = 0;
      m_dcnt   = '0;
      m_err    = 0;
      mf.delete();
      gap_end  = 0;
      draining = 0;
      occ      = 0;
      rdq.delete();
    end else begin
      avail = (pn > inflight) ? pn - inflight : 0;
      p1    = (per < 1) ? 1 : per;
      if (m_fire) gap_end = cyc + p1;
      if (draining) dn = (inflight != 0);
      else if (!en && cyc < gap_end) begin
        dn      = 1;
        gap_end = 0;
      end else dn = 0;
      fire_n = !draining && !dn && en && (avail > 0) && (cyc + 1 >= gap_end);
      busy_n = fire_n || dn || (cyc + 1 < gap_end);
      m_dcnt = clr ? 32'(m_fire) : m_dcnt + 32'(m_fire);
      m_err  = clr ? 1'b0 : (m_err | (pn < inflight));
      draining = dn;
      if (fire_n) mf.push_back(cyc + 1);
    end
    m_fire = fire_n;
    exp_q.push_back({fire_n, busy_n, m_err, m_dcnt});
    @(posedge dst_clk);
    #2;
    cyc++;
  endtask

  task automatic do_reset();
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    strobes = 0;
    fq.delete();
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [34:0] e;
    forever begin
      @(posedge dst_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rd_pulse !== e[34] || step_out !== e[34] || busy !== e[33] ||
            err_underrun !== e[32] || dispatch_cnt !== e[31:0]) begin
          n_errors++;
          if (n_prints < 40) begin
            n_prints++;
            $display("FAIL outputs cycle %0d: rd=%b step=%b busy=%b err=%b cnt=%0d expected rd=%b busy=%b err=%b cnt=%0d",
                     cyc, rd_pulse, step_out, busy, err_underrun, dispatch_cnt,
                     e[34], e[33], e[32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    dst_rst = 1'b1; cfg_en = 1'b0; cfg_period = '0; cfg_clr = 1'b0; pulse_num = '0;
    @(posedge dst_clk);
    #2;

    // 3 pulses, period 4
    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt", int'(dispatch_cnt), 0);
    step(1, 4, 0, 3, 0, 0);
    repeat (15) step(1, 4, 0, 0, 0, 0);
    chk("p4_strobes", strobes, 3);
    if (fq.size() >= 3) begin
      chk("p4_gap1", fq[1] - fq[0], 4);
      chk("p4_gap2", fq[2] - fq[1], 4);
    end
    chk("p4_cnt", int'(dispatch_cnt), 3);
    chk("p4_err", int'(err_underrun), 0);

    // 5 pulses, period 0: back-to-back without over-dispatch
    do_reset();
    step(1, 0, 0, 5, 0, 0);
    repeat (11) step(1, 0, 0, 0, 0, 0);
    chk("p0_strobes", strobes, 5);
    if (fq.size() == 5) chk("p0_span", fq[4] - fq[0], 4);

    // enable dropped in the gap after pulse 2 of 10
    do_reset();
    for (int i = 0; i < 40; i++) step(strobes < 2, 4, 0, (i == 0) ? 10 : 0, 0, 0);
    chk("drop_strobes", strobes, 2);
    chk("drop_busy", int'(busy), 0);
    chk("drop_cnt", int'(dispatch_cnt), 2);

    // pulse_num forced to 0 with two strobes in flight
    do_reset();
    for (int i = 0; i < 12; i++) step(1, 1, 0, (i == 0) ? 2 : 0, strobes >= 2, 0);
    chk("under_err", int'(err_underrun), 1);
    chk("under_strobes", strobes, 2);
    step(1, 1, 1, 0, 1, 0);
    repeat (4) step(1, 1, 0, 0, 0, 0);
    chk("clr_err", int'(err_underrun), 0);
    chk("clr_cnt", int'(dispatch_cnt), 0);

    // period changed 8 -> 2 during the first gap
    do_reset();
    for (int i = 0; i < 30; i++) step(1, (strobes >= 1) ? 2 : 8, 0, (i == 0) ? 6 : 0, 0, 0);
    chk("per_strobes", strobes, 6);
    if (fq.size() >= 3) begin
      chk("per_gap_old", fq[1] - fq[0], 8);
      chk("per_gap_new", fq[2] - fq[1], 2);
    end

    // reset asserted in a FIRE cycle
    do_reset();
    rst_on_fire = 1;
    for (int i = 0; i < 6; i++) step(1, 3, 0, (i == 0) ? 4 : 0, 0, 0);
    rst_on_fire = 0;
    chk("rstfire_strobes", strobes, 1);
    chk("rstfire_rd", int'(rd_pulse), 0);
    chk("rstfire_state", int'(dbg_state), 0);
    chk("rstfire_cnt", int'(dispatch_cnt), 0);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 5),
           $urandom_range(0, 29) == 0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 199) == 0);
    end
    repeat (12) step(0, 1, 0, 0, 0, 0);
    chk("end_busy", int'(busy), 0);

    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
